// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO pair.
// MULT*/DIV* take WIDTH+1 cycles after acceptance; MTHI/MTLO and divide-by-zero complete at the accept edge.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  localparam logic [1:0]       GRP_MUL  = 2'b00;
  localparam logic [1:0]       GRP_DIV  = 2'b01;
  localparam logic [1:0]       GRP_MT   = 2'b10;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] f_abs(input logic signed [WIDTH-1:0] v, input logic is_signed);
    return f_neg_w(v, is_signed && (v < 0));
  endfunction

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_mt;
  logic               w_signed;
  logic               w_b_zero;
  logic               w_go_calc;
  logic               w_accept_calc;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_sub;
  logic               w_div_ok;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_is_mul      = (op[2:1] == GRP_MUL);
  assign w_is_div      = (op[2:1] == GRP_DIV);
  assign w_is_mt       = (op[2:1] == GRP_MT);
  assign w_signed      = op[0];
  assign w_b_zero      = (SrcB == '0);
  assign w_go_calc     = w_is_mul || (w_is_div && !w_b_zero);
  assign w_accept_calc = (r_state == S_IDLE) && start && w_go_calc;
  assign w_a_abs       = f_abs(SrcA, w_signed);
  assign w_b_abs       = f_abs(SrcB, w_signed);

  // Multiply step: r_acc = {partial product high, remaining multiplier bits}
  assign w_addend   = r_acc[0] ? r_b : '0;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: r_acc = {partial remainder, dividend bits shifting into quotient}.
  // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
  // and bit WIDTH of the difference is the borrow.
  assign w_div_sub  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};
  assign w_div_ok   = ~w_div_sub[WIDTH];
  assign w_div_next = w_div_ok ? {w_div_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                               : {r_acc[2*WIDTH-2:0], 1'b0};

  // Sign correction; MIN/-1 falls out naturally as quotient MIN, remainder 0
  assign w_prod   = f_neg_2w(r_acc, r_neg_q);
  assign w_res_hi = r_is_div ? f_neg_w(r_acc[2*WIDTH-1:WIDTH], r_neg_r) : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? f_neg_w(r_acc[WIDTH-1:0], r_neg_q)       : w_prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_go_calc) begin
              r_state    <= S_CALC;
              r_busy     <= 1'b1;
              r_cnt      <= '0;
              r_div_zero <= 1'b0;
            end else if (w_is_div) begin
              r_hi       <= SrcA;
              r_lo       <= '1;
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else if (w_is_mt) begin
              if (op[0]) r_lo <= SrcA;
              else       r_hi <= SrcA;
              r_done     <= 1'b1;
              r_div_zero <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand/iteration datapath: loaded at acceptance, stepped once per CALC cycle
  always_ff @(posedge clk) begin
    if (w_accept_calc) begin
      r_is_div <= w_is_div;
      r_neg_q  <= w_signed && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
      r_neg_r  <= w_signed && SrcA[WIDTH-1];
      r_b      <= w_is_div ? w_b_abs : w_a_abs;
      r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_abs : w_b_abs)};
    end else if (r_state == S_CALC) begin
      r_acc <= r_is_div ? w_div_next : w_mul_next;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign HI       = r_hi;
  assign LO       = r_lo;

endmodule
